// File: rtl/wallace_mac_sequencer.sv
// Time-shares one external 8x8 multiplier over a stream of operand pairs and accumulates a job of `len` products.
// Optional: define WALLACE_MAC_SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module wallace_mac_sequencer #(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic [7:0]       mul_a,
  output logic [7:0]       mul_b,
  input  logic [15:0]      mul_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state;
  logic [LEN_W-1:0] remain;
  logic             s1_vld;
  logic             s2_vld;
  logic [15:0]      prod_q;
  logic [ACC_W-1:0] acc;
  logic             ovf;

  logic             hs;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_nxt;
  logic             ovf_nxt;

  assign hs      = in_valid & in_ready;
  assign out_acc = acc;
  assign out_ovf = ovf;
  assign busy    = (state != IDLE);

  // Extra top bit of the sum is the carry out of the accumulator.
  assign sum = {1'b0, acc} + {{(ACC_W - 15){1'b0}}, prod_q};

  always_comb begin
    ovf_nxt = ovf | sum[ACC_W];
`ifdef WALLACE_MAC_SATURATE_EN
    acc_nxt = ovf_nxt ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    acc_nxt = sum[ACC_W-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      remain    <= '0;
      in_ready  <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      s1_vld    <= 1'b0;
      s2_vld    <= 1'b0;
      prod_q    <= '0;
      acc       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      s1_vld <= hs;
      if (hs) begin
        mul_a <= in_a;
        mul_b <= in_b;
      end
      s2_vld <= s1_vld;
      if (s1_vld) begin
        prod_q <= mul_p;
      end
      if (s2_vld) begin
        acc <= acc_nxt;
        ovf <= ovf_nxt;
      end

      case (state)
        IDLE: begin
          if (start) begin
            remain <= len;
            acc    <= '0;
            ovf    <= 1'b0;
            if (len != '0) begin
              state    <= RUN;
              in_ready <= 1'b1;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
            end
          end
        end
        RUN: begin
          if (hs) begin
            remain <= remain - LEN_W'(1);
            if (remain == LEN_W'(1)) begin
              in_ready <= 1'b0;
              state    <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Both stages empty means the final accumulate has already landed.
          if (!s1_vld && !s2_vld) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wallace_mac_sequencer.sv
// Scoreboard bench for wallace_mac_sequencer with an exact 8x8 multiplier model and ACC_W=16.
module tb_wallace_mac_sequencer;
  localparam int ACC_W = 16;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       in_a = '0;
  logic [7:0]       in_b = '0;
  logic [7:0]       mul_a;
  logic [7:0]       mul_b;
  logic [15:0]      mul_p;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [ACC_W-1:0] out_acc;
  logic             out_ovf;
  logic             busy;

  wallace_mac_sequencer #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_ovf(out_ovf), .busy(busy)
  );

  assign mul_p = 16'(mul_a) * 16'(mul_b);

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ACC_W-1:0] acc;
    logic             ovf;
  } res_t;

  res_t       exp_q[$];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] va[8];
  logic [7:0] vb[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: pops one expected result per accepted output.
  always @(negedge clk) begin
    res_t e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got acc=%0d with no job outstanding", out_acc);
      end else begin
        e = exp_q.pop_front();
        chk("out_acc", 32'(out_acc), 32'(e.acc));
        chk("out_ovf", 32'(out_ovf), 32'(e.ovf));
      end
    end
  end

  task automatic run_job(input int l, input logic [ACC_W-1:0] ea, input logic eo,
                         input bit bubbles, input int hold, input bit ign_start);
    int cyc;
    int n;
    int bound;
    bit hs;
    exp_q.push_back(res_t'{acc: ea, ovf: eo});
    out_ready = (hold == 0);
    @(posedge clk); #1;
    start = 1'b1;
    len   = LEN_W'(l);
    @(posedge clk); #1;
    start = 1'b0;
    cyc   = 1;
    n     = 0;
    bound = 0;
    while (n < l && bound < 200) begin
      in_valid = bubbles ? (cyc % 2 == 1) : 1'b1;
      in_a     = va[n];
      in_b     = vb[n];
      if (ign_start && n == 0) begin
        start = 1'b1;
        len   = 8'd9;
      end
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      start = 1'b0;
      if (hs) n++;
      cyc++;
      bound++;
    end
    in_valid = 1'b0;
    chk("in_ready_low_after_last", 32'(in_ready), 32'd0);
    while (!out_valid && bound < 200) begin
      @(posedge clk); #1;
      cyc++;
      bound++;
    end
    chk("out_valid_seen", 32'(out_valid), 32'd1);
    if (!bubbles) chk("job_latency", 32'(cyc), (l == 0) ? 32'd1 : 32'(l + 4));
    if (hold > 0) begin
      repeat (hold) begin
        @(negedge clk);
        chk("held_valid", 32'(out_valid), 32'd1);
        chk("held_acc", 32'(out_acc), 32'(ea));
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
    end
    bound = 0;
    while (busy && bound < 20) begin
      @(posedge clk); #1;
      bound++;
    end
    chk("idle_after_job", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_acc", 32'(out_acc), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Reset mid-RUN after 3 of 5 pairs: partial job is discarded.
    va[0] = 8'd2; vb[0] = 8'd3;
    va[1] = 8'd4; vb[1] = 8'd5;
    va[2] = 8'd6; vb[2] = 8'd7;
    @(posedge clk); #1;
    start = 1'b1;
    len   = 8'd5;
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_a = va[i];
      in_b = vb[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("busy_before_reset", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_out_acc", 32'(out_acc), 32'd0);
    chk("midrst_mul_a", 32'(mul_a), 32'd0);
    chk("midrst_mul_b", 32'(mul_b), 32'd0);
    chk("midrst_out_ovf", 32'(out_ovf), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Fresh job after reset: 7*9 + 2*3 = 69
    va[0] = 8'd7; vb[0] = 8'd9;
    va[1] = 8'd2; vb[1] = 8'd3;
    run_job(2, 16'd69, 1'b0, 1'b0, 0, 1'b0);

    // Basic: 15 + 100 + 255 + 0 = 370
    va[0] = 8'd3;   vb[0] = 8'd5;
    va[1] = 8'd10;  vb[1] = 8'd10;
    va[2] = 8'd255; vb[2] = 8'd1;
    va[3] = 8'd0;   vb[3] = 8'd77;
    run_job(4, 16'd370, 1'b0, 1'b0, 0, 1'b0);

    // Bubbles + backpressure: 2 + 12 + 30 = 44
    va[0] = 8'd1; vb[0] = 8'd2;
    va[1] = 8'd3; vb[1] = 8'd4;
    va[2] = 8'd5; vb[2] = 8'd6;
    run_job(3, 16'd44, 1'b0, 1'b1, 5, 1'b0);

    // Zero length
    run_job(0, 16'd0, 1'b0, 1'b0, 0, 1'b0);

    // Overflow: 65025 + 65025 = 130050
    va[0] = 8'd255; vb[0] = 8'd255;
    va[1] = 8'd255; vb[1] = 8'd255;
`ifdef WALLACE_MAC_SATURATE_EN
    run_job(2, 16'hFFFF, 1'b1, 1'b0, 0, 1'b0);
`else
    run_job(2, 16'hFC02, 1'b1, 1'b0, 0, 1'b0);
`endif

    // Ignored start during RUN: 600 + 2000 = 2600, ovf cleared from prior job
    va[0] = 8'd20; vb[0] = 8'd30;
    va[1] = 8'd40; vb[1] = 8'd50;
    run_job(2, 16'd2600, 1'b0, 1'b0, 0, 1'b1);

    repeat (4) @(posedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
